// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a valid/ready output stage.
// Define IMM_FUSE_EN to fuse a CALL upper immediate (101) with the following I-type immediate.
module imm_extend_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUSE_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [2:0]            ImmSrc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic                  imm_fused
);

  function automatic logic [31:0] ext32(input logic [31:0] iw, input logic [2:0] src);
    logic [31:0] r;
    case (src)
      3'b001:  r = {{17{iw[28]}}, iw[28:14]};
      3'b010:  r = {{17{iw[28]}}, iw[28:19], iw[4:0]};
      3'b011:  r = {{4{iw[28]}}, iw[28:13], iw[9:0], 2'b00};
      3'b100:  r = {{14{iw[28]}}, iw[28:13], 2'b00};
      3'b101:  r = {iw[28:9], 12'b0};
      default: r = {{18{iw[27]}}, iw[27:14]};
    endcase
    return r;
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] ext_dw;
  logic                  unused_bits;

  assign out_free  = !valid_q || out_ready;
  assign ext_dw    = DATA_WIDTH'(signed'(ext32(instr, ImmSrc)));
  assign out_valid = valid_q;
  assign ImmOp     = imm_q;

`ifdef IMM_FUSE_EN
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [3:0] TO_LIM  = 4'(FUSE_TIMEOUT);
  localparam logic [3:0] TO_LAST = 4'(FUSE_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [19:0]           upper_q, upper_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  fused_q, fused_d;
  logic                  is_itype;
  logic [DATA_WIDTH-1:0] upper_dw, lower_dw;

  assign unused_bits = ^instr[31:29];
  assign imm_fused   = fused_q;
  assign is_itype    = (ImmSrc == 3'b000) || (ImmSrc[2:1] == 2'b11);
  assign upper_dw    = DATA_WIDTH'(signed'({upper_q, 12'b0}));
  assign lower_dw    = DATA_WIDTH'(signed'({{18{instr[27]}}, instr[27:14]}));

  always_comb begin
    state_d  = state_q;
    upper_d  = upper_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q && !out_ready;
    imm_d    = imm_q;
    fused_d  = fused_q;
    in_ready = 1'b0;
    if (flush || !rst_n) begin
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready = out_free;
          if (in_valid && out_free) begin
            if (ImmSrc == 3'b101) begin
              upper_d = instr[28:9];
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              valid_d = 1'b1;
              imm_d   = ext_dw;
              fused_d = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (in_valid && is_itype) begin
            in_ready = out_free;
            if (out_free) begin
              valid_d = 1'b1;
              imm_d   = upper_dw + lower_dw;
              fused_d = 1'b1;
              state_d = S_IDLE;
            end
          end else if (in_valid) begin
            // Non-partner instruction stalls here; the upper drains alone first.
            if (out_free) begin
              valid_d = 1'b1;
              imm_d   = upper_dw;
              fused_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = (cnt_q >= TO_LIM) ? cnt_q : cnt_q + 4'd1;
            if (cnt_q >= TO_LAST && out_free) begin
              valid_d = 1'b1;
              imm_d   = upper_dw;
              fused_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      upper_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      imm_q   <= '0;
      fused_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upper_q <= upper_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      imm_q   <= imm_d;
      fused_q <= fused_d;
    end
  end
`else
  assign unused_bits = ^{instr[31:29], 4'(FUSE_TIMEOUT)};
  assign imm_fused   = 1'b0;

  always_comb begin
    valid_d  = valid_q && !out_ready;
    imm_d    = imm_q;
    in_ready = 1'b0;
    if (flush || !rst_n) begin
      valid_d = 1'b0;
    end else begin
      in_ready = out_free;
      if (in_valid && out_free) begin
        valid_d = 1'b1;
        imm_d   = ext_dw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, directed handshake/fusion
// sequences and randomized traffic against a transaction-level reference model.
module tb_imm_extend_pipe;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, imm_fused;
  logic [31:0]   instr;
  logic [2:0]    ImmSrc;
  logic [DW-1:0] ImmOp;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.DATA_WIDTH(DW), .FUSE_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ImmSrc(ImmSrc), .out_valid(out_valid), .out_ready(out_ready),
    .ImmOp(ImmOp), .imm_fused(imm_fused)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   n_vec;

  // Spec-level reference: pick the field, weight it, sign-extend with plain arithmetic.
  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] s);
    longint f, width, scale;
    case (s)
      3'd1: begin f = longint'(w >> 14) & 64'h7FFF; width = 15; scale = 1; end
      3'd2: begin f = (longint'(w >> 19) & 64'h3FF) * 32 + (longint'(w) & 64'h1F); width = 15; scale = 1; end
      3'd3: begin f = (longint'(w >> 13) & 64'hFFFF) * 1024 + (longint'(w) & 64'h3FF); width = 26; scale = 4; end
      3'd4: begin f = longint'(w >> 13) & 64'hFFFF; width = 16; scale = 4; end
      3'd5: begin f = longint'(w >> 9) & 64'hFFFFF; width = 20; scale = 4096; end
      default: begin f = longint'(w >> 14) & 64'h3FFF; width = 14; scale = 1; end
    endcase
    if (f >= (64'sd1 << (width - 1))) f = f - (64'sd1 << width);
    return 32'(f * scale);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s, input logic ordy);
    in_valid  = v;
    instr     = w;
    ImmSrc    = s;
    out_ready = ordy;
    #1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] exp, input logic fused);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, 64'(ImmOp), 64'(exp));
    chk({name, "_fused"}, 64'(imm_fused), 64'(fused));
  endtask

  logic        m_valid;
  logic [31:0] m_imm;
  logic        exp_rdy;
  logic        saw_out;

  initial begin
    vecs[0]  = '{32'h17FF_FFFF, 3'b000, 32'h0000_1FFF};
    vecs[1]  = '{32'h0FFF_C000, 3'b000, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h1007_FFE0, 3'b010, 32'hFFFF_C000};
    vecs[3]  = '{32'h0FF8_0015, 3'b010, 32'h0000_3FF5};
    vecs[4]  = '{32'h1000_3FFF, 3'b001, 32'hFFFF_C000};
    vecs[5]  = '{32'h0000_3C00, 3'b011, 32'h0000_1000};
    vecs[6]  = '{32'h1000_03FF, 3'b011, 32'hF800_0FFC};
    vecs[7]  = '{32'h1000_1FFF, 3'b100, 32'hFFFE_0000};
    vecs[8]  = '{32'h0246_8000, 3'b100, 32'h0000_48D0};
    vecs[9]  = '{32'h0800_0000, 3'b110, 32'hFFFF_E000};
    vecs[10] = '{32'hE000_4000, 3'b111, 32'h0000_0001};
    n_vec = 11;
`ifndef IMM_FUSE_EN
    vecs[11] = '{32'h0246_8A00, 3'b101, 32'h1234_5000};
    vecs[12] = '{32'h1000_0000, 3'b101, 32'h8000_0000};
    n_vec = 13;
`endif

    // Reset
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h0FFF_C000, 3'b000, 1'b0);
    cyc(); cyc();
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, '0, 3'b000, 1'b0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(ImmOp), 64'd0);
    chk("rst_fused", 64'(imm_fused), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Vector table, back-to-back at full throughput
    for (int i = 0; i < n_vec; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].src, 1'b1);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end
    drive(1'b0, '0, 3'b000, 1'b1);
    cyc();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Back-pressure: output held, input refused, then take and accept on one edge
    drive(1'b1, 32'h17FF_FFFF, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 32'h0FFF_C000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      cyc();
      chk_out("bp_hold", 32'h0000_1FFF, 1'b0);
    end
    drive(1'b1, 32'h0FFF_C000, 3'b000, 1'b1);
    chk("bp_release_rdy", 64'(in_ready), 64'd1);
    cyc();
    chk_out("bp_new", 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, '0, 3'b000, 1'b1);
    cyc();

`ifdef IMM_FUSE_EN
    // Fused pair
    drive(1'b1, 32'h0246_8A00, 3'b101, 1'b1);
    chk("fuse_up_rdy", 64'(in_ready), 64'd1);
    cyc();
    chk("fuse_up_no_out", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h019E_0000, 3'b000, 1'b1);
    chk("fuse_lo_rdy", 64'(in_ready), 64'd1);
    cyc();
    chk_out("fuse", 32'h1234_5678, 1'b1);
    drive(1'b0, '0, 3'b000, 1'b1);
    cyc();
    chk("fuse_single", 64'(out_valid), 64'd0);

    // Upper followed by non-partner: upper drains alone, then the stalled one
    drive(1'b1, 32'h0246_8A00, 3'b101, 1'b1);
    cyc();
    drive(1'b1, 32'h0000_2000, 3'b011, 1'b1);
    chk("stall_rdy_low", 64'(in_ready), 64'd0);
    cyc();
    chk_out("stall_upper", 32'h1234_5000, 1'b0);
    chk("stall_rdy_high", 64'(in_ready), 64'd1);
    cyc();
    chk_out("stall_second", 32'h0000_1000, 1'b0);
    drive(1'b0, '0, 3'b000, 1'b1);
    cyc();

    // Timeout after four idle cycles
    drive(1'b1, 32'h0246_8A00, 3'b101, 1'b1);
    cyc();
    drive(1'b0, '0, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("to_wait%0d", i), 64'(out_valid), 64'd0);
    end
    cyc();
    chk_out("timeout", 32'h1234_5000, 1'b0);
    cyc();
    chk("timeout_once", 64'(out_valid), 64'd0);

    // Flush mid-HOLD discards the upper
    drive(1'b1, 32'h0246_8A00, 3'b101, 1'b1);
    cyc();
    flush = 1'b1;
    drive(1'b0, '0, 3'b000, 1'b1);
    chk("flush_rdy", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    saw_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid) saw_out = 1'b1;
    end
    chk("flush_no_out", 64'(saw_out), 64'd0);
`endif

    // Randomized traffic against the one-entry output register model
    flush   = 1'b0;
    m_valid = 1'b0;
    m_imm   = '0;
    for (int c = 0; c < 400; c++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
`ifdef IMM_FUSE_EN
      if (s == 3'b101) s = 3'b000;
`endif
      flush = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 9) < 7), $urandom, s, ($urandom_range(0, 9) < 7));
      exp_rdy = !flush && (!m_valid || out_ready);
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      cyc();
      if (flush) m_valid = 1'b0;
      else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && exp_rdy) begin
          m_valid = 1'b1;
          m_imm   = ref_ext(instr, ImmSrc);
        end
      end
      chk("rnd_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_imm", 64'(ImmOp), 64'(m_imm));
        chk("rnd_fused", 64'(imm_fused), 64'd0);
      end
    end
    flush = 1'b0;

    // Reset clears a held output
    drive(1'b1, 32'h17FF_FFFF, 3'b000, 1'b1);
    cyc();
    drive(1'b0, '0, 3'b000, 1'b0);
    cyc();
    chk_out("pre_reset", 32'h0000_1FFF, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("reset2_valid", 64'(out_valid), 64'd0);
    chk("reset2_imm", 64'(ImmOp), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
